// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-and-add multiplier with start/done handshake
// Optional SEQ_MULT_SIGNED_EN adds signed_mode for two's-complement operands.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  // Upper half is the running sum; lower half doubles as the multiplier shift register.
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  logic neg_load;

  always_comb begin
    a_load   = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_load   = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    neg_load = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  always_comb begin
    a_load = a;
    b_load = b;
  end
`endif

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    acc_next = {sum, acc[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
    result   = neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
`else
    result   = acc_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a_load;
            acc   <= {{WIDTH{1'b0}}, b_load};
            cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg   <= neg_load;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            product <= result;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - directed self-checking bench for seq_shift_add_mult (WIDTH=8)
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef SEQ_MULT_SIGNED_EN
  logic           signed_mode;
`endif
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy(busy),
    .done(done),
    .product(product)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start with the given operands and wait (bounded) for done.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2*W-1:0] exp);
    bit got;
    got   = 1'b0;
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!got) begin
        step();
        if (done) got = 1'b1;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_product"}, 32'(product), 32'(exp));
    step();
  endtask

  initial begin
    int first_t;
    int second_t;
    int ndone;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SEQ_MULT_SIGNED_EN
    signed_mode = 1'b0;
`endif

    // Reset
    step();
    step();
    rst_n = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'h0000);
    step();

    // 255*255 with exact timing
    a = 8'd255; b = 8'd255; start = 1'b1;
    step();
    start = 1'b0;
    check("ff_busy_after_accept", 32'(busy), 32'd1);
    ndone = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (done) ndone++;
    end
    check("ff_no_early_done", 32'(ndone), 32'd0);
    step();
    check("ff_done_at_k8", 32'(done), 32'd1);
    check("ff_busy_at_k8", 32'(busy), 32'd1);
    check("ff_product", 32'(product), 32'hFE01);
    step();
    check("ff_done_low_k9", 32'(done), 32'd0);
    check("ff_busy_low_k9", 32'(busy), 32'd0);
    check("ff_product_held", 32'(product), 32'hFE01);

    // 13*11 with start held for 20 cycles
    a = 8'd13; b = 8'd11; start = 1'b1;
    first_t = -1; second_t = -1; ndone = 0;
    for (int t = 1; t <= 20; t++) begin
      step();
      if (done) begin
        ndone++;
        check("b2b_product", 32'(product), 32'h008F);
        if (first_t < 0) first_t = t;
        else if (second_t < 0) second_t = t;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_first_done", 32'(first_t), 32'd9);
    check("b2b_spacing", 32'(second_t - first_t), 32'd10);
    step();

    // Reset at fourth RUN edge abandons the operation
    a = 8'd100; b = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_product", 32'(product), 32'h0000);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) ndone++;
    end
    check("rst_mid_no_done", 32'(ndone), 32'd0);
    do_op("after_rst", 8'd2, 8'd9, 16'h0012);

    // Start during RUN is ignored
    a = 8'd0; b = 8'd200; start = 1'b1;
    step();
    a = 8'd7; b = 8'd7;
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) start = 1'b0;
      if (i < 8 && done) ndone++;
    end
    check("ign_no_early_done", 32'(ndone), 32'd0);
    check("ign_done", 32'(done), 32'd1);
    check("ign_product", 32'(product), 32'h0000);
    step();
    a = 8'd99; b = 8'd99;
    step();
    step();
    step();
    check("ign_idle_busy", 32'(busy), 32'd0);
    check("ign_idle_product_held", 32'(product), 32'h0000);

`ifdef SEQ_MULT_SIGNED_EN
    signed_mode = 1'b1;
    do_op("s_80x80", 8'h80, 8'h80, 16'h4000);
    do_op("s_fdx05", 8'hFD, 8'h05, 16'hFFF1);
    signed_mode = 1'b0;
    do_op("u_fdx05", 8'hFD, 8'h05, 16'h04F1);
`else
    do_op("u_fdx05", 8'hFD, 8'h05, 16'h04F1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
